vram_fill_dma: RTL
==================

VRAM_FILL_DMA -- requirements
Module: vram_fill_dma

Interface
REQ-001 Parameter: ADDR_W, 11, video RAM address width (2048 cells per plane).
REQ-002 Parameter: LEN_W, 12, transfer length counter width; max length 2048.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high; reset is sampled on the clk_sys edge and overrides all other inputs.
REQ-005 reg_cs  in  1  CPU register window select.
REQ-006 reg_addr  in  3  register index.
REQ-007 reg_wr  in  1  CPU write strobe, qualified by reg_cs.
REQ-008 reg_din  in  8  CPU write data.
REQ-009 reg_dout  out  8  CPU read data, combinational from reg_addr.
REQ-010 cpu_vram_req  in  1  CPU accessing chram, fgcolram or bgcolram this cycle.
REQ-011 dma_we  out  1  engine write strobe to the video RAM port A.
REQ-012 dma_sel  out  3  one-hot target: bit0 chram, bit1 fgcolram, bit2 bgcolram.
REQ-013 dma_addr  out  ADDR_W  target cell address.
REQ-014 dma_data  out  8  fill value.
REQ-015 busy  out  1  transfer in progress.
REQ-016 done  out  1  sticky completion flag.

Function
REQ-017 Registers: 0 ADDR_LO; 1 ADDR_HI[2:0]; 2 LEN_LO; 3 LEN_HI[3:0]; 4 VALUE; 5 MASK[2:0] (target planes); 6 CTRL (write) / STATUS (read); 7 reads 0x00.
REQ-018 CTRL write bits: bit0 START, bit1 ABORT, bit2 CLR_DONE, bit3 INC (VALUE increments by 1 mod 256 after each cell).
REQ-019 STATUS read = {6'b0, done, busy}; registers 0-5 read back the last written value; unused bits read 0.
REQ-020 Writes to registers 0-5 while busy=1 shall be ignored; START while busy=1 shall be ignored.
REQ-021 FSM states IDLE, RUN, DONE; IDLE->RUN on START with LEN!=0 and MASK!=0; IDLE->DONE on START with LEN=0 or MASK=0.
REQ-022 On START, the engine latches ADDR, LEN, VALUE, MASK and INC into working copies; busy=1 from the next cycle.
REQ-023 In RUN, each cell is written once per set MASK bit, in order chram, fgcolram, bgcolram, with one write per granted cycle.
REQ-024 Arbitration: CPU priority. When cpu_vram_req=1, dma_we=0 and the engine holds all state that cycle.
REQ-025 Cycle with cpu_vram_req=0 in RUN: dma_we=1, with dma_sel, dma_addr and dma_data valid in the same cycle.
REQ-026 After the last selected plane of a cell: address increments and wraps 0x7FF->0x000; remaining length decrements; value increments if INC is set.
REQ-027 When the final write completes: transition RUN->DONE; busy=0 on the next cycle.
REQ-028 DONE lasts one cycle, sets done=1, then returns to IDLE.
REQ-029 Uncontended duration = LEN x popcount(MASK) write cycles; each CPU-held cycle adds exactly one cycle.
REQ-030 ABORT while in RUN: dma_we=0 in that cycle; next state is IDLE with done unchanged. Partial writes stand.
REQ-031 START and ABORT set in the same write: ABORT wins, and no transfer starts.
REQ-032 CLR_DONE clears done; when it coincides with DONE-state entry, done shall end set.
REQ-033 dma_we=0 in every state except RUN; dma_sel=0 whenever dma_we=0.

Reset
REQ-034 Reset: FSM=IDLE; busy=0; done=0; dma_we=0; dma_sel=0; dma_addr=0; dma_data=0; all registers=0.
REQ-035 Reset asserted mid-transfer stops writes in the same cycle: dma_we=0 from the reset edge onward, and no further writes occur.

Verification
REQ-036 ADDR=0x000, LEN=4, VALUE=0x20, MASK=001, START, no CPU traffic -> chram writes at 0x000-0x003 of 0x20 in 4 consecutive cycles; busy high 4 cycles; done=1.
REQ-037 ADDR=0x7FE, LEN=3, MASK=111, INC=1, VALUE=0xFF -> 9 writes; addresses 0x7FE, 0x7FF, 0x000; values 0xFF, 0x00, 0x01; plane order ch, fg, bg per cell.
REQ-038 LEN=8, MASK=010, with cpu_vram_req high on alternate cycles -> no dma_we while cpu_vram_req=1; 8 fgcolram writes complete in 16 cycles.
REQ-039 LEN=0 START -> zero writes; done=1 two cycles after the START write; busy never asserted.
REQ-040 LEN=100 START, ABORT after 10 writes -> dma_we low from the ABORT cycle; busy=0 next cycle; done=0; register writes accepted afterwards.
REQ-041 Reset pulse during a LEN=50 transfer -> dma_we=0 immediately; STATUS=0x00; ADDR_LO reads 0x00.

Source files
------------

// File: rtl/vram_fill_dma.sv
// Purpose: CPU-programmed fill engine that writes VALUE into a range of video RAM cells across chram/fgcolram/bgcolram.
// Latency: busy the cycle after START; one plane write per granted cycle; done set one cycle after the final write.
// Backpressure: cpu_vram_req always wins the RAM port; the engine holds all state in any cycle it is denied.
//
// Ports:
//   clk_sys, reset                      - system clock, synchronous active-high reset
//   reg_cs/reg_addr/reg_wr/reg_din      - CPU register window (8 registers)
//   reg_dout                            - CPU read data, combinational from reg_addr
//   cpu_vram_req                        - CPU owns the video RAM this cycle
//   dma_we/dma_sel/dma_addr/dma_data    - engine write port (dma_sel one-hot: ch, fg, bg)
//   busy, done                          - transfer in progress, sticky completion flag
module vram_fill_dma #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 12
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              reg_cs,
    input  logic [2:0]        reg_addr,
    input  logic              reg_wr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    input  logic              cpu_vram_req,
    output logic              dma_we,
    output logic [2:0]        dma_sel,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [7:0]        dma_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;

    // CPU-visible configuration registers
    logic [7:0] r_addr_lo;
    logic [2:0] r_addr_hi;
    logic [7:0] r_len_lo;
    logic [3:0] r_len_hi;
    logic [7:0] r_val;
    logic [2:0] r_mask;

    // Working copies owned by the engine during a transfer
    logic [ADDR_W-1:0] w_addr;
    logic [LEN_W-1:0]  w_len;
    logic [7:0]        w_val;
    logic [2:0]        w_mask;
    logic [2:0]        w_pend;   // planes still to write for the current cell
    logic              w_inc;

    logic [ADDR_W-1:0] cfg_addr;
    logic [LEN_W-1:0]  cfg_len;
    logic              reg_we;
    logic              ctrl_wr;
    logic              start_req;
    logic              abort_req;
    logic              clr_req;
    logic              cfg_we;
    logic              grant;
    logic [2:0]        cur_sel;
    logic [2:0]        pend_left;
    logic              cell_end;
    logic              last_write;

    assign cfg_addr = ADDR_W'({r_addr_hi, r_addr_lo});
    assign cfg_len  = LEN_W'({r_len_hi, r_len_lo});

    assign reg_we    = reg_cs & reg_wr;
    assign ctrl_wr   = reg_we & (reg_addr == 3'd6);
    // ABORT in the same write suppresses START
    assign start_req = ctrl_wr & reg_din[0] & ~reg_din[1];
    assign abort_req = ctrl_wr & reg_din[1];
    assign clr_req   = ctrl_wr & reg_din[2];
    assign cfg_we    = reg_we & (reg_addr <= 3'd5) & (state != S_RUN);

    assign busy = (state == S_RUN);

    // Lowest pending plane gives ch -> fg -> bg ordering within a cell
    assign cur_sel    = w_pend & (~w_pend + 3'd1);
    assign pend_left  = w_pend & ~cur_sel;
    assign cell_end   = (pend_left == 3'd0);
    assign last_write = cell_end & (w_len == LEN_W'(1));

    // Write strobe is combinational so CPU contention, ABORT and reset all
    // suppress the write in the very cycle they appear.
    assign grant    = (state == S_RUN) & ~cpu_vram_req & ~abort_req & ~reset;
    assign dma_we   = grant;
    assign dma_sel  = grant ? cur_sel : 3'd0;
    assign dma_addr = w_addr;
    assign dma_data = w_val;

    always_comb begin
        reg_dout = 8'h00;
        case (reg_addr)
            3'd0:    reg_dout = r_addr_lo;
            3'd1:    reg_dout = {5'b0, r_addr_hi};
            3'd2:    reg_dout = r_len_lo;
            3'd3:    reg_dout = {4'b0, r_len_hi};
            3'd4:    reg_dout = r_val;
            3'd5:    reg_dout = {5'b0, r_mask};
            3'd6:    reg_dout = {6'b0, done, busy};
            default: reg_dout = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            r_addr_lo <= 8'h00;
            r_addr_hi <= 3'd0;
            r_len_lo  <= 8'h00;
            r_len_hi  <= 4'd0;
            r_val     <= 8'h00;
            r_mask    <= 3'd0;
            w_addr    <= '0;
            w_len     <= '0;
            w_val     <= 8'h00;
            w_mask    <= 3'd0;
            w_pend    <= 3'd0;
            w_inc     <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (reg_addr)
                    3'd0:    r_addr_lo <= reg_din;
                    3'd1:    r_addr_hi <= reg_din[2:0];
                    3'd2:    r_len_lo  <= reg_din;
                    3'd3:    r_len_hi  <= reg_din[3:0];
                    3'd4:    r_val     <= reg_din;
                    3'd5:    r_mask    <= reg_din[2:0];
                    default: ;
                endcase
            end

            // Completion set takes priority over a coincident CLR_DONE
            if (state == S_DONE) begin
                done <= 1'b1;
            end else if (clr_req) begin
                done <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        w_addr <= cfg_addr;
                        w_len  <= cfg_len;
                        w_val  <= r_val;
                        w_mask <= r_mask;
                        w_pend <= r_mask;
                        w_inc  <= reg_din[3];
                        state  <= ((cfg_len != '0) && (r_mask != 3'd0)) ? S_RUN : S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (abort_req) begin
                        state <= S_IDLE;
                    end else if (grant) begin
                        if (cell_end) begin
                            w_addr <= w_addr + ADDR_W'(1);
                            w_len  <= w_len - LEN_W'(1);
                            w_pend <= w_mask;
                            if (w_inc) begin
                                w_val <= w_val + 8'd1;
                            end
                            if (last_write) begin
                                state <= S_DONE;
                            end
                        end else begin
                            w_pend <= pend_left;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
